// File: rtl/fb_pixel_pipe.sv
// Framebuffer-to-VGA pixel pipeline: incremental raster addressing, pixel doubling,
// read-latency tracking and RGB expansion. FB_BIT_REPLICATE_EN selects MSB-replicated colour fill.
module fb_pixel_pipe #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int R_BITS      = 3,
  parameter int G_BITS      = 3,
  parameter int B_BITS      = 2,
  parameter int ADDR_W      = 19,
  parameter int RD_LAT      = 1,
  parameter int SCALE_SHIFT = 0,
  localparam int PIX_W      = R_BITS + G_BITS + B_BITS
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              pix_en,
  output logic [ADDR_W-1:0] read_address,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              pix_valid_out,
  output logic              overrun
);

  localparam int NPIX = H_RES * V_RES;
  localparam int XW   = $clog2(H_RES);
  localparam int YW   = $clog2(V_RES);
  localparam int TW   = $clog2(NPIX + 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES >> SCALE_SHIFT);
  localparam logic [YW:0]       SMASK     = (YW+1)'((1 << SCALE_SHIFT) - 1);

  logic [XW-1:0]     xcnt;
  logic [YW-1:0]     ycnt;
  logic [ADDR_W-1:0] line_base;
  logic [TW-1:0]     pix_total;
  logic [RD_LAT-1:0] vld_p;
  logic [RD_LAT-1:0] ovr_p;

  // frame_start zeroes the raster position seen by a same-cycle pixel
  logic [XW-1:0]     x_cur;
  logic [YW-1:0]     y_cur;
  logic [ADDR_W-1:0] lb_cur;
  logic [TW-1:0]     tot_cur;
  logic [YW:0]       y_p1;
  logic [YW-1:0]     y_inc;
  logic              full;
  logic              last_x;
  logic              repeat_line;

  always_comb begin
    x_cur       = frame_start ? '0 : xcnt;
    y_cur       = frame_start ? '0 : ycnt;
    lb_cur      = frame_start ? '0 : line_base;
    tot_cur     = frame_start ? '0 : pix_total;
    full        = (tot_cur == TW'(NPIX));
    last_x      = (x_cur == XW'(H_RES - 1));
    y_p1        = {1'b0, y_cur} + 1'b1;
    y_inc       = (y_cur == YW'(V_RES - 1)) ? '0 : y_p1[YW-1:0];
    repeat_line = |(y_p1 & SMASK);
  end

  logic [7:0] r_lj, g_lj, b_lj;
  logic [7:0] r_exp, g_exp, b_exp;

  assign r_lj = 8'(mem_data[PIX_W-1 -: R_BITS]) << (8 - R_BITS);
  assign g_lj = 8'(mem_data[B_BITS +: G_BITS]) << (8 - G_BITS);
  assign b_lj = 8'(mem_data[0 +: B_BITS]) << (8 - B_BITS);

`ifdef FB_BIT_REPLICATE_EN
  function automatic logic [7:0] fill(input logic [7:0] lj, input int w);
    logic [7:0] o;
    o = lj;
    for (int i = 0; i < 8; i++)
      if (i >= w) o[7-i] = lj[7-(i % w)];
    return o;
  endfunction

  assign r_exp = fill(r_lj, R_BITS);
  assign g_exp = fill(g_lj, G_BITS);
  assign b_exp = fill(b_lj, B_BITS);
`else
  assign r_exp = r_lj;
  assign g_exp = g_lj;
  assign b_exp = b_lj;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      xcnt          <= '0;
      ycnt          <= '0;
      line_base     <= '0;
      pix_total     <= '0;
      read_address  <= '0;
      overrun       <= 1'b0;
      vld_p         <= '0;
      ovr_p         <= '0;
      pix_valid_out <= 1'b0;
      VGA_R         <= '0;
      VGA_G         <= '0;
      VGA_B         <= '0;
    end else begin
      if (frame_start) begin
        xcnt      <= '0;
        ycnt      <= '0;
        line_base <= '0;
        pix_total <= '0;
        overrun   <= 1'b0;
      end
      if (pix_en) begin
        if (full) begin
          overrun <= 1'b1;
        end else begin
          read_address <= lb_cur + ADDR_W'(x_cur >> SCALE_SHIFT);
          pix_total    <= tot_cur + 1'b1;
          if (last_x) begin
            xcnt <= '0;
            ycnt <= y_inc;
            line_base <= repeat_line ? lb_cur : lb_cur + LINE_STEP;
          end else begin
            xcnt <= x_cur + 1'b1;
          end
        end
      end

      // Valid/overrun tags ride alongside the memory latency; frame_start does not flush them
      vld_p[0] <= pix_en;
      ovr_p[0] <= pix_en & full;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        ovr_p[i] <= ovr_p[i-1];
      end

      pix_valid_out <= vld_p[RD_LAT-1];
      if (vld_p[RD_LAT-1] && !ovr_p[RD_LAT-1]) begin
        VGA_R <= r_exp;
        VGA_G <= g_exp;
        VGA_B <= b_exp;
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_pixel_pipe.sv
// Randomised bench for fb_pixel_pipe: three parameterisations share one stimulus stream and are
// checked every cycle against a pixel-index reference model and a due-cycle scoreboard.
module tb_fb_pixel_pipe;

  localparam int NI = 3;
  localparam int P_H  [NI] = '{640, 16, 12};
  localparam int P_V  [NI] = '{480,  8,  6};
  localparam int P_S  [NI] = '{  0,  1,  0};
  localparam int P_L  [NI] = '{  1,  2,  4};
  localparam int P_AW [NI] = '{ 19, 19,  6};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic [18:0] ra_a, ra_b;
  logic [5:0]  ra_c;
  logic [7:0]  md_a, md_b, md_c;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic        v_a, v_b, v_c, o_a, o_b, o_c;

  function automatic logic [7:0] mfun(input int a);
    return 8'(a * 29 + (a >> 3) + 7);
  endfunction

  // Memory models: address register in the DUT plus RD_LAT-1 further stages
  logic [18:0] qb;
  logic [5:0]  qc0, qc1, qc2;
  always @(posedge clk) begin
    qb  <= ra_b;
    qc0 <= ra_c;
    qc1 <= qc0;
    qc2 <= qc1;
  end
  assign md_a = mfun(int'(ra_a));
  assign md_b = mfun(int'(qb));
  assign md_c = mfun(int'(qc2));

  fb_pixel_pipe dut_a (
    .Clk(clk), .Reset_n(rst_n), .frame_start(frame_start), .pix_en(pix_en),
    .read_address(ra_a), .mem_data(md_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
    .pix_valid_out(v_a), .overrun(o_a)
  );

  fb_pixel_pipe #(.H_RES(16), .V_RES(8), .RD_LAT(2), .SCALE_SHIFT(1)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .frame_start(frame_start), .pix_en(pix_en),
    .read_address(ra_b), .mem_data(md_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
    .pix_valid_out(v_b), .overrun(o_b)
  );

  fb_pixel_pipe #(.H_RES(12), .V_RES(6), .ADDR_W(6), .RD_LAT(4), .SCALE_SHIFT(0)) dut_c (
    .Clk(clk), .Reset_n(rst_n), .frame_start(frame_start), .pix_en(pix_en),
    .read_address(ra_c), .mem_data(md_c), .VGA_R(r_c), .VGA_G(g_c), .VGA_B(b_c),
    .pix_valid_out(v_c), .overrun(o_c)
  );

  logic [31:0] ob_addr [NI];
  logic [31:0] ob_ovr  [NI];
  logic [31:0] ob_vld  [NI];
  logic [31:0] ob_r    [NI];
  logic [31:0] ob_g    [NI];
  logic [31:0] ob_b    [NI];
  assign ob_addr[0] = 32'(ra_a); assign ob_addr[1] = 32'(ra_b); assign ob_addr[2] = 32'(ra_c);
  assign ob_ovr[0]  = 32'(o_a);  assign ob_ovr[1]  = 32'(o_b);  assign ob_ovr[2]  = 32'(o_c);
  assign ob_vld[0]  = 32'(v_a);  assign ob_vld[1]  = 32'(v_b);  assign ob_vld[2]  = 32'(v_c);
  assign ob_r[0]    = 32'(r_a);  assign ob_r[1]    = 32'(r_b);  assign ob_r[2]    = 32'(r_c);
  assign ob_g[0]    = 32'(g_a);  assign ob_g[1]    = 32'(g_b);  assign ob_g[2]    = 32'(g_c);
  assign ob_b[0]    = 32'(b_a);  assign ob_b[1]    = 32'(b_b);  assign ob_b[2]    = 32'(b_c);

  typedef struct {
    int inst;
    int due;
    int r;
    int g;
    int b;
  } ent_t;

  ent_t sb[$];
  int   idx    [NI];
  int   e_addr [NI];
  int   e_ovr  [NI];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Channel of w bits stretched to 8: zero fill, or the bit pattern repeated down from the MSB
  function automatic int expand(input int v, input int w);
`ifdef FB_BIT_REPLICATE_EN
    int acc = 0;
    for (int sh = 8 - w; sh > -w; sh -= w)
      acc |= (sh >= 0) ? (v << sh) : (v >> (-sh));
    return acc & 255;
`else
    return (v << (8 - w)) & 255;
`endif
  endfunction

  task automatic model_clear();
    sb.delete();
    for (int i = 0; i < NI; i++) begin
      idx[i] = 0; e_addr[i] = 0; e_ovr[i] = 0;
    end
  endtask

  task automatic model_accept(input bit fs, input bit pe);
    ent_t e;
    int k, a, d;
    if (!rst_n) return;
    for (int i = 0; i < NI; i++) begin
      if (fs) begin
        idx[i] = 0; e_ovr[i] = 0;
      end
      if (pe) begin
        e.inst = i;
        e.due  = cyc + P_L[i] + 1;
        if (idx[i] >= P_H[i] * P_V[i]) begin
          e_ovr[i] = 1;
          e.r = 0; e.g = 0; e.b = 0;
        end else begin
          k = idx[i];
          a = (((k / P_H[i]) >> P_S[i]) * (P_H[i] >> P_S[i]) + ((k % P_H[i]) >> P_S[i]))
              % (1 << P_AW[i]);
          e_addr[i] = a;
          d = int'(mfun(a));
          e.r = expand(d >> 5, 3);
          e.g = expand((d >> 2) & 7, 3);
          e.b = expand(d & 3, 2);
          idx[i]++;
        end
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_outputs();
    int f;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("addr%0d", i), ob_addr[i], 32'(e_addr[i]));
      check($sformatf("overrun%0d", i), ob_ovr[i], 32'(e_ovr[i]));
      f = -1;
      for (int j = 0; j < sb.size(); j++)
        if (sb[j].inst == i && sb[j].due == cyc) f = j;
      if (f >= 0) begin
        check($sformatf("valid%0d", i), ob_vld[i], 32'd1);
        check($sformatf("vga_r%0d", i), ob_r[i], 32'(sb[f].r));
        check($sformatf("vga_g%0d", i), ob_g[i], 32'(sb[f].g));
        check($sformatf("vga_b%0d", i), ob_b[i], 32'(sb[f].b));
        sb.delete(f);
      end else begin
        check($sformatf("valid%0d", i), ob_vld[i], 32'd0);
        check($sformatf("vga_r%0d", i), ob_r[i], 32'd0);
        check($sformatf("vga_g%0d", i), ob_g[i], 32'd0);
        check($sformatf("vga_b%0d", i), ob_b[i], 32'd0);
      end
    end
  endtask

  task automatic tick(input bit fs, input bit pe);
    frame_start = fs;
    pix_en      = pe;
    model_accept(fs, pe);
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic do_reset(input int low_cycles);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs();
    for (int i = 0; i < low_cycles; i++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    #1;
    check_outputs();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    rst_n = 1'b1;

    // frame_start coincident with the first pixel, then a dense stream across a 640-pixel line
    tick(1'b1, 1'b1);
    for (int i = 0; i < 1300; i++) tick(1'b0, $urandom_range(0, 9) != 0);

    // line-sized bursts separated by long blanking gaps
    tick(1'b1, 1'b0);
    for (int l = 0; l < 10; l++) begin
      for (int p = 0; p < 16; p++) tick(1'b0, 1'b1);
      for (int g = 0; g < 160; g++) tick(1'b0, 1'b0);
    end

    // reset in the middle of a line with pixels in flight, resume without frame_start
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1);
    do_reset(3);
    for (int i = 0; i < 40; i++) tick(1'b0, $urandom_range(0, 3) != 0);

    // long random run with occasional frame_start pulses
    for (int i = 0; i < 4000; i++)
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
